// File: rtl/pipelined_shift_unit_pkg.sv
// Shared definitions for the two-stage shifter/rotator: op encodings,
// per-stage fill modes and the bit-reverse helper used to turn SLL into SRL.
package pipelined_shift_unit_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } shiftOp_t;

    typedef enum logic [1:0] {
        MODE_LOGIC  = 2'b00,
        MODE_ARITH  = 2'b01,
        MODE_ROTATE = 2'b10
    } stageMode_t;

    // SLL runs through the right-shift stages on a reversed word, so it is logical.
    function automatic stageMode_t opToMode(input shiftOp_t op);
        stageMode_t mode;
        case (op)
            OP_SRA:  mode = MODE_ARITH;
            OP_ROTR: mode = MODE_ROTATE;
            default: mode = MODE_LOGIC;
        endcase
        return mode;
    endfunction

    function automatic logic [WIDTH-1:0] bitReverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_shift_unit_stage.sv
// One fixed-distance right stage of the barrel shifter; passes data through
// when disabled, otherwise shifts by DIST with zero, sign or rotate fill.
module shift_stage_right
    import pipelined_shift_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic              enable,
    input  stageMode_t        mode,
    input  logic              fill,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut
);

    always_comb begin
        dataOut = dataIn;
        if (enable) begin
            case (mode)
                MODE_ROTATE: dataOut = {dataIn[DIST-1:0], dataIn[DATA_W-1:DIST]};
                MODE_ARITH:  dataOut = {{DIST{fill}}, dataIn[DATA_W-1:DIST]};
                default:     dataOut = {{DIST{1'b0}}, dataIn[DATA_W-1:DIST]};
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Two-stage elastic 32-bit shifter/rotator (SLL/SRL/SRA/ROTR): 16/8 stages
// before the first register, 4/2/1 stages before the output register.
module pipelined_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    import pipelined_shift_unit_pkg::*;

    logic outLoad;
    logic s1Load;

    shiftOp_t   inOp;
    stageMode_t inMode;
    logic       inFill;
    logic [WIDTH-1:0] inPre;
    logic [WIDTH-1:0] st16Out;
    logic [WIDTH-1:0] st8Out;

    logic             s1Valid;
    logic [WIDTH-1:0] s1Data;
    shiftOp_t         s1Op;
    logic [2:0]       s1Shamt;
    logic             s1Fill;

    stageMode_t       s1Mode;
    logic [WIDTH-1:0] st4Out;
    logic [WIDTH-1:0] st2Out;
    logic [WIDTH-1:0] st1Out;
    logic [WIDTH-1:0] result;

    logic             outValid;
    logic [WIDTH-1:0] outData;

    // Elastic control: a full output stage frees up in the same cycle it is read.
    assign outLoad  = !outValid || out_ready;
    assign s1Load   = !s1Valid || outLoad;
    assign in_ready = s1Load;

    assign inOp   = shiftOp_t'(in_op);
    assign inMode = opToMode(inOp);
    assign inFill = (inOp == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
    assign inPre  = (inOp == OP_SLL) ? bitReverse(in_data) : in_data;

    shift_stage_right #(.DATA_W(WIDTH), .DIST(16)) uStage16 (
        .enable (in_shamt[4]),
        .mode   (inMode),
        .fill   (inFill),
        .dataIn (inPre),
        .dataOut(st16Out)
    );

    shift_stage_right #(.DATA_W(WIDTH), .DIST(8)) uStage8 (
        .enable (in_shamt[3]),
        .mode   (inMode),
        .fill   (inFill),
        .dataIn (st16Out),
        .dataOut(st8Out)
    );

    // The sign bit travels with the op so stage 2 fills from the original operand.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Data  <= '0;
            s1Op    <= OP_SLL;
            s1Shamt <= '0;
            s1Fill  <= 1'b0;
        end else if (s1Load) begin
            s1Valid <= in_valid;
            s1Data  <= st8Out;
            s1Op    <= inOp;
            s1Shamt <= in_shamt[2:0];
            s1Fill  <= inFill;
        end
    end

    assign s1Mode = opToMode(s1Op);

    shift_stage_right #(.DATA_W(WIDTH), .DIST(4)) uStage4 (
        .enable (s1Shamt[2]),
        .mode   (s1Mode),
        .fill   (s1Fill),
        .dataIn (s1Data),
        .dataOut(st4Out)
    );

    shift_stage_right #(.DATA_W(WIDTH), .DIST(2)) uStage2 (
        .enable (s1Shamt[1]),
        .mode   (s1Mode),
        .fill   (s1Fill),
        .dataIn (st4Out),
        .dataOut(st2Out)
    );

    shift_stage_right #(.DATA_W(WIDTH), .DIST(1)) uStage1 (
        .enable (s1Shamt[0]),
        .mode   (s1Mode),
        .fill   (s1Fill),
        .dataIn (st2Out),
        .dataOut(st1Out)
    );

    assign result = (s1Op == OP_SLL) ? bitReverse(st1Out) : st1Out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else if (outLoad) begin
            outValid <= s1Valid;
            outData  <= result;
        end
    end

    assign out_valid = outValid;
    assign out_data  = outData;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit: the driver queues expected results
// on each accepted request, the monitor pops and compares on each output handshake.
module tb_pipelined_shift_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int outCount = 0;
    bit latOn = 1'b0;

    logic [31:0] expQ[$];
    int          latQ[$];

    pipelined_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] op);
        logic [63:0] t;
        logic [31:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $signed(d) >>> s;
            default: begin
                t = {d, d} >> s;
                r = t[31:0];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                         input logic [31:0] exp);
        int waitCnt = 0;
        bit done = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        while (!done) begin
            #1;
            if (in_ready) begin
                expQ.push_back(exp);
                latQ.push_back(cycle);
                done = 1'b1;
                @(posedge clock);
            end else begin
                waitCnt++;
                if (waitCnt > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
                    done = 1'b1;
                end else begin
                    @(negedge clock);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic setReady(input logic v);
        @(negedge clock);
        out_ready = v;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_empty", 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    initial begin
        int lat;
        logic [31:0] exp;
        forever begin
            @(negedge clock);
            #2;
            if (out_valid && out_ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%08h, expected no result", out_data);
                end else begin
                    exp = expQ.pop_front();
                    lat = latQ.pop_front();
                    check("result", out_data, exp);
                    if (latOn) check("latency", 32'(cycle - lat), 32'd2);
                end
            end
        end
    end

    initial begin
        int base;
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  ro;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed single ops with latency checking
        setReady(1'b1);
        latOn = 1'b1;
        issue(32'h8000_0000, 5'd2,  2'b10, 32'hE000_0000);
        issue(32'h8000_0000, 5'd2,  2'b01, 32'h2000_0000);
        issue(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        issue(32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000);
        issue(32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456);
        issue(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        issue(32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
        issue(32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003);
        for (int op = 0; op < 4; op++) begin
            issue(32'hDEAD_BEEF, 5'd0, 2'(op), 32'hDEAD_BEEF);
        end
        idle();
        drain();

        // Back-pressure: two accepted, then the pipe stalls
        latOn = 1'b0;
        base  = outCount;
        setReady(1'b0);
        issue(32'hF000_0000, 5'd4, 2'b01, 32'h0F00_0000);
        issue(32'h0000_000F, 5'd4, 2'b00, 32'h0000_00F0);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'h8000_F000;
        in_shamt = 5'd16;
        in_op    = 2'b10;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("bp_out_data_stable", out_data, 32'h0F00_0000);
            check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(32'h8000_F000, 5'd16, 2'b10, 32'hFFFF_8000);
        issue(32'hA5A5_A5A5, 5'd1,  2'b11, 32'hD2D2_D2D2);
        idle();
        drain();
        check("bp_result_count", 32'(outCount - base), 32'd4);

        // Streaming random requests, one per cycle
        latOn = 1'b1;
        base  = outCount;
        for (int i = 0; i < 16; i++) begin
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            ro = 2'($urandom_range(0, 3));
            issue(rd, rs, ro, refShift(rd, rs, ro));
        end
        idle();
        drain();
        check("stream_result_count", 32'(outCount - base), 32'd16);

        // Reset with two results in flight
        latOn = 1'b0;
        setReady(1'b0);
        issue(32'h1111_1111, 5'd1, 2'b01, 32'h0888_8888);
        issue(32'h2222_2222, 5'd1, 2'b01, 32'h1111_1111);
        idle();
        #1;
        check("inflight_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_out_data", out_data, 32'd0);
        expQ.delete();
        latQ.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("after_reset_in_ready", {31'd0, in_ready}, 32'd1);
        base = outCount;
        setReady(1'b1);
        repeat (5) @(negedge clock);
        #1;
        check("no_stale_out_valid", {31'd0, out_valid}, 32'd0);
        check("no_stale_count", 32'(outCount - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
